// File: rtl/alu_pkg.sv
// Shared opcodes, flag positions and command layout for the ALU issue stage.
// The optional accumulator forwarding path is enabled with `define ACC_FWD_EN.
package alu_pkg;

   localparam int unsigned ALU_W = 8;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_INC = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_NOT = 3'd5;
   localparam logic [2:0] OP_SHL = 3'd6;
   localparam logic [2:0] OP_NOP = 3'd7;

   localparam int unsigned FLG_C = 3;
   localparam int unsigned FLG_N = 2;
   localparam int unsigned FLG_Z = 1;
   localparam int unsigned FLG_P = 0;

   // Default-width view of a queued command; the FIFO stores the same layout flat.
   typedef struct packed {
      logic             use_acc;
      logic [2:0]       op;
      logic [ALU_W-1:0] b;
      logic [ALU_W-1:0] a;
   } alu_cmd_t;

   localparam int unsigned ALU_CMD_W = $bits(alu_cmd_t);

   function automatic int unsigned cmd_width(input int unsigned w, input bit with_acc);
      return 2 * w + 3 + (with_acc ? 1 : 0);
   endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Bundle of the command, ALU and result channels of alu_issue_stage.
// master = command source / ALU / result consumer side, slave = the issue stage.
interface alu_issue_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [2:0]       in_op;
   logic             in_use_acc;

   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [2:0]       alu_op;
   logic [WIDTH-1:0] alu_y;
   logic [3:0]       alu_flags;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_y;
   logic [3:0]       out_flags;
   logic [LVL_W-1:0] level;

   modport master (
      output in_valid, in_a, in_b, in_op, in_use_acc, alu_y, alu_flags, out_ready,
      input  in_ready, alu_a, alu_b, alu_op, out_valid, out_y, out_flags, level
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, in_use_acc, alu_y, alu_flags, out_ready,
      output in_ready, alu_a, alu_b, alu_op, out_valid, out_y, out_flags, level
   );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with combinational head read and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module alu_cmd_fifo #(
   parameter int unsigned WIDTH_W = 19,
   parameter int unsigned DEPTH   = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH_W-1:0]         wdata_i,
   output logic [WIDTH_W-1:0]         rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     level_o
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   logic [WIDTH_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]   level_q, level_d;
   logic               do_push, do_pop;

   assign full_o  = (level_q == LVL_W'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // A full FIFO refuses the push even when the head pops in the same cycle.
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the combinational 8-bit ALU: command FIFO plus registered result slot.
// `define ACC_FWD_EN adds an accumulator that can replace operand a of a queued command.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input logic        clk,
   input logic        reset,
   alu_issue_if.slave bus
);
`ifdef ACC_FWD_EN
   localparam bit ACC_EN = 1'b1;
`else
   localparam bit ACC_EN = 1'b0;
`endif
   localparam int unsigned CMD_W = cmd_width(WIDTH, ACC_EN);
   localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

   logic [CMD_W-1:0] wdata, rdata;
   logic             full, empty, push, capture;
   logic [LVL_W-1:0] level;
   logic [WIDTH-1:0] head_a, head_b;
   logic [2:0]       head_op;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_y_q, out_y_d;
   logic [3:0]       out_flags_q, out_flags_d;

   assign push = bus.in_valid && !full;

`ifdef ACC_FWD_EN
   logic             head_use_acc;
   logic [WIDTH-1:0] acc_q, acc_d;

   assign wdata        = {bus.in_use_acc, bus.in_op, bus.in_b, bus.in_a};
   assign head_use_acc = rdata[2*WIDTH+3];
`else
   logic unused_in_use_acc;

   assign wdata             = {bus.in_op, bus.in_b, bus.in_a};
   assign unused_in_use_acc = bus.in_use_acc;
`endif

   assign head_a  = rdata[WIDTH-1:0];
   assign head_b  = rdata[2*WIDTH-1:WIDTH];
   assign head_op = rdata[2*WIDTH+2:2*WIDTH];

   alu_cmd_fifo #(
      .WIDTH_W (CMD_W),
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .pop_i   (capture),
      .wdata_i (wdata),
      .rdata_o (rdata),
      .full_o  (full),
      .empty_o (empty),
      .level_o (level)
   );

   always_comb begin
      bus.alu_a  = '0;
      bus.alu_b  = '0;
      bus.alu_op = OP_NOP;
      if (!empty) begin
         bus.alu_a  = head_a;
         bus.alu_b  = head_b;
         bus.alu_op = head_op;
`ifdef ACC_FWD_EN
         if (head_use_acc) bus.alu_a = acc_q;
`endif
      end
   end

   // The slot reloads whenever it is empty or being drained this cycle.
   assign capture = !empty && (!out_valid_q || bus.out_ready);

   always_comb begin
      out_valid_d = out_valid_q;
      out_y_d     = out_y_q;
      out_flags_d = out_flags_q;
      if (capture) begin
         out_valid_d = 1'b1;
         out_y_d     = bus.alu_y;
         out_flags_d = bus.alu_flags;
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_y_q     <= '0;
         out_flags_q <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_y_q     <= out_y_d;
         out_flags_q <= out_flags_d;
      end
   end

`ifdef ACC_FWD_EN
   assign acc_d = capture ? bus.alu_y : acc_q;

   always_ff @(posedge clk) begin
      if (reset) acc_q <= '0;
      else       acc_q <= acc_d;
   end
`endif

   assign bus.in_ready  = !full;
   assign bus.out_valid = out_valid_q;
   assign bus.out_y     = out_y_q;
   assign bus.out_flags = out_flags_q;
   assign bus.level     = level;

endmodule
